// File: rtl/luma4x4_recon.sv
`default_nettype none
// ============================================================================
//  Module      : luma4x4_recon
//  Description : 4x4 luma intra reconstruction: prediction + residual rows,
//                clipped to PIX_W bits, plus neighbour samples for the next
//                block. Optional macro LUMA_RECON_CLIPCNT_EN adds clip_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module luma4x4_recon #(
    parameter int RES_W = 9,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [16*PIX_W-1:0]  pred_in,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [4*RES_W-1:0]   res_row,
    output logic                 rec_valid,
    output logic [1:0]           rec_row_idx,
    output logic [4*PIX_W-1:0]   rec_row,
    output logic                 nbr_valid,
    output logic [4*PIX_W-1:0]   nbr_top,
    output logic [4*PIX_W-1:0]   nbr_left,
    output logic [PIX_W-1:0]     nbr_corner,
    output logic                 busy
`ifdef LUMA_RECON_CLIPCNT_EN
    ,
    output logic [4:0]           clip_count
`endif
);

    localparam int c_sum_w = RES_W + 2;
    localparam logic signed [c_sum_w-1:0] c_max = c_sum_w'((2 ** PIX_W) - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_rows = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           r_row;
    logic [16*PIX_W-1:0]  r_pred;
    logic [PIX_W-1:0]     r_left0;
    logic [PIX_W-1:0]     r_left1;
    logic [PIX_W-1:0]     r_left2;

    logic                 w_acc;
    logic [3:0]           w_lo;
    logic [3:0]           w_hi;
    logic [4*PIX_W-1:0]   w_rec;
    logic [PIX_W-1:0]     w_col3;

    assign w_acc  = (r_state == c_rows) && res_valid;
    assign w_col3 = w_rec[3*PIX_W +: PIX_W];

    // Per-column add and clip of the row currently being accepted
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [3:0]                 w_idx;
        logic [PIX_W-1:0]           w_pred;
        logic [RES_W-1:0]           w_res;
        logic signed [c_sum_w-1:0]  w_sum;

        assign w_idx  = {r_row, 2'(c)};
        assign w_pred = r_pred[w_idx*PIX_W +: PIX_W];
        assign w_res  = res_row[c*RES_W +: RES_W];
        assign w_sum  = $signed({{(c_sum_w-PIX_W){1'b0}}, w_pred})
                      + $signed({{2{w_res[RES_W-1]}}, w_res});
        assign w_lo[c] = w_sum[c_sum_w-1];
        assign w_hi[c] = !w_sum[c_sum_w-1] && (w_sum > c_max);
        assign w_rec[c*PIX_W +: PIX_W] = w_lo[c] ? '0 :
                                         w_hi[c] ? '1 : w_sum[PIX_W-1:0];
    end

`ifdef LUMA_RECON_CLIPCNT_EN
    logic [3:0] w_clip;
    logic [4:0] w_clip_add;
    assign w_clip     = w_lo | w_hi;
    assign w_clip_add = 5'(w_clip[0]) + 5'(w_clip[1]) + 5'(w_clip[2]) + 5'(w_clip[3]);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_row       <= 2'd0;
            r_pred      <= '0;
            r_left0     <= '0;
            r_left1     <= '0;
            r_left2     <= '0;
            res_ready   <= 1'b0;
            rec_valid   <= 1'b0;
            rec_row_idx <= 2'd0;
            rec_row     <= '0;
            nbr_valid   <= 1'b0;
            nbr_top     <= '0;
            nbr_left    <= '0;
            nbr_corner  <= '0;
            busy        <= 1'b0;
`ifdef LUMA_RECON_CLIPCNT_EN
            clip_count  <= 5'd0;
`endif
        end else begin
            rec_valid <= 1'b0;
            nbr_valid <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state   <= c_rows;
                        r_pred    <= pred_in;
                        r_row     <= 2'd0;
                        res_ready <= 1'b1;
                        busy      <= 1'b1;
`ifdef LUMA_RECON_CLIPCNT_EN
                        clip_count <= 5'd0;
`endif
                    end
                end
                c_rows: begin
                    if (w_acc) begin
                        rec_row     <= w_rec;
                        rec_row_idx <= r_row;
                        rec_valid   <= 1'b1;
                        r_row       <= r_row + 2'd1;
`ifdef LUMA_RECON_CLIPCNT_EN
                        clip_count  <= clip_count + w_clip_add;
`endif
                        case (r_row)
                            2'd0:    r_left0 <= w_col3;
                            2'd1:    r_left1 <= w_col3;
                            2'd2:    r_left2 <= w_col3;
                            default: begin
                                // Last row: publish neighbours alongside row 3
                                r_state    <= c_done;
                                res_ready  <= 1'b0;
                                nbr_valid  <= 1'b1;
                                nbr_top    <= w_rec;
                                nbr_left   <= {w_col3, r_left2, r_left1, r_left0};
                                nbr_corner <= w_col3;
                            end
                        endcase
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state   <= c_idle;
                    res_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_luma4x4_recon.sv
`default_nettype none
// ============================================================================
//  Module      : tb_luma4x4_recon
//  Description : Scoreboard bench for luma4x4_recon with directed blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_luma4x4_recon;

    localparam int RES_W = 9;
    localparam int PIX_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [16*PIX_W-1:0] pred_in;
    logic                res_valid;
    logic                res_ready;
    logic [4*RES_W-1:0]  res_row;
    logic                rec_valid;
    logic [1:0]          rec_row_idx;
    logic [4*PIX_W-1:0]  rec_row;
    logic                nbr_valid;
    logic [4*PIX_W-1:0]  nbr_top;
    logic [4*PIX_W-1:0]  nbr_left;
    logic [PIX_W-1:0]    nbr_corner;
    logic                busy;
`ifdef LUMA_RECON_CLIPCNT_EN
    logic [4:0]          clip_count;
`endif

    luma4x4_recon #(.RES_W(RES_W), .PIX_W(PIX_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pred_in     (pred_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_row     (res_row),
        .rec_valid   (rec_valid),
        .rec_row_idx (rec_row_idx),
        .rec_row     (rec_row),
        .nbr_valid   (nbr_valid),
        .nbr_top     (nbr_top),
        .nbr_left    (nbr_left),
        .nbr_corner  (nbr_corner),
        .busy        (busy)
`ifdef LUMA_RECON_CLIPCNT_EN
        ,
        .clip_count  (clip_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] row;
        int          cyc;
    } rec_t;

    typedef struct {
        logic [31:0] top;
        logic [31:0] left;
        logic [7:0]  corner;
        logic [4:0]  clip;
        int          cyc;
    } nbr_t;

    rec_t rq[$];
    nbr_t nq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one
    always @(negedge clk) begin
        if (rec_valid) begin
            if (rq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rec_unexpected: got idx %0d row %0h expected no pulse", rec_row_idx, rec_row);
            end else begin
                rec_t e;
                e = rq.pop_front();
                chk("rec_idx", 64'(rec_row_idx), 64'(e.idx));
                chk("rec_row", 64'(rec_row), 64'(e.row));
                chk("rec_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (nbr_valid) begin
            if (nq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL nbr_unexpected: got nbr_valid=1 expected 0");
            end else begin
                nbr_t e;
                e = nq.pop_front();
                chk("nbr_top", 64'(nbr_top), 64'(e.top));
                chk("nbr_left", 64'(nbr_left), 64'(e.left));
                chk("nbr_corner", 64'(nbr_corner), 64'(e.corner));
                chk("nbr_cycle", 64'(cyc), 64'(e.cyc));
`ifdef LUMA_RECON_CLIPCNT_EN
                chk("clip_count", 64'(clip_count), 64'(e.clip));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef logic [4*RES_W-1:0] res_a_t [4];
    typedef logic [31:0]        row_a_t [4];

    // Runs one block; pat gives res_valid per cycle (1 after npat entries)
    task automatic run_block(input logic [127:0] pred, input res_a_t res, input row_a_t exp,
                             input logic [15:0] pat, input int npat, input logic [4:0] eclip,
                             input bit midstart, input bit donestart);
        int   k = 0;
        int   i = 0;
        logic v;
        start = 1'b1; pred_in = pred;
        tick();
        start = 1'b0; pred_in = '0;
        chk("ready_in_rows", 64'(res_ready), 64'd1);
        chk("busy_in_rows", 64'(busy), 64'd1);
        while (k < 4) begin
            v = (i < npat) ? pat[i] : 1'b1;
            res_valid = v;
            res_row   = res[k];
            if (midstart && i == 1) begin
                start = 1'b1; pred_in = {16{8'hFF}};
            end
            if (v) begin
                rq.push_back('{idx: 2'(k), row: exp[k], cyc: cyc + 1});
                if (k == 3)
                    nq.push_back('{top: exp[3],
                                   left: {exp[3][31:24], exp[2][31:24], exp[1][31:24], exp[0][31:24]},
                                   corner: exp[3][31:24], clip: eclip, cyc: cyc + 1});
            end
            tick();
            start = 1'b0; pred_in = '0;
            if (v) k++;
            i++;
        end
        res_valid = 1'b0;
        chk("ready_done", 64'(res_ready), 64'd0);
        chk("busy_done", 64'(busy), 64'd1);
        if (donestart) begin
            start = 1'b1; pred_in = {16{8'h55}};
        end
        tick();
        start = 1'b0;
        chk("busy_idle", 64'(busy), 64'd0);
        chk("ready_idle", 64'(res_ready), 64'd0);
    endtask

    res_a_t r_flat, r_zero, r_clip, r_ramp;
    row_a_t e_flat, e_nbr, e_clip, e_ramp;
    localparam logic [127:0] P_RAMP = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    initial begin
        reset = 1'b1; start = 1'b0; pred_in = '0; res_valid = 1'b0; res_row = '0;
        for (int j = 0; j < 4; j++) begin
            r_flat[j] = {4{9'd5}};
            r_zero[j] = '0;
            r_clip[j] = {9'h19C, 9'h19C, 9'd100, 9'd100};
            r_ramp[j] = {4{9'(10 * j)}};
            e_flat[j] = 32'h85858585;
            e_clip[j] = 32'h0000FFFF;
        end
        e_nbr  = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        e_ramp = '{32'h03020100, 32'h11100F0E, 32'h1F1E1D1C, 32'h2D2C2B2A};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(res_ready), 64'd0);
        chk("rst_rec_valid", 64'(rec_valid), 64'd0);
        chk("rst_nbr_valid", 64'(nbr_valid), 64'd0);
        chk("rst_rec_row", 64'(rec_row), 64'd0);
        chk("rst_nbr_top", 64'(nbr_top), 64'd0);
        tick();

        run_block({16{8'h80}}, r_flat, e_flat, 16'h0, 0, 5'd0, 1'b0, 1'b1);
        run_block({4{32'h1010F0F0}}, r_clip, e_clip, 16'h0, 0, 5'd16, 1'b0, 1'b0);
        // 1,0,0,1,0,1,1 with bit 0 applied first
        run_block(P_RAMP, r_ramp, e_ramp, 16'b110_1001, 7, 5'd0, 1'b0, 1'b0);
        run_block(P_RAMP, r_zero, e_nbr, 16'b01, 2, 5'd0, 1'b1, 1'b0);
        chk("nbr_hold_top", 64'(nbr_top), 64'h0F0E0D0C);
        chk("rec_row_hold", 64'(rec_row), 64'h0F0E0D0C);

        // Abandon a block after two rows
        start = 1'b1; pred_in = {16{8'h80}};
        tick();
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            res_valid = 1'b1; res_row = r_flat[j];
            rq.push_back('{idx: 2'(j), row: 32'h85858585, cyc: cyc + 1});
            tick();
        end
        res_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(res_ready), 64'd0);
        chk("midrst_rec_valid", 64'(rec_valid), 64'd0);
        chk("midrst_nbr_top", 64'(nbr_top), 64'd0);
        tick();
        chk("midrst_nbr_valid", 64'(nbr_valid), 64'd0);

        // start together with reset: reset wins
        start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        chk("startrst_busy", 64'(busy), 64'd0);
        tick();

        run_block({16{8'h80}}, r_flat, e_flat, 16'h0, 0, 5'd0, 1'b0, 1'b0);

        for (int j = 0; j < 10 && (rq.size() != 0 || nq.size() != 0); j++) tick();
        if (rq.size() != 0 || nq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d rec and %0d nbr outstanding expected 0", rq.size(), nq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/luma4x4_recon.md
Name: luma4x4_recon

Overview:
- Decoder-side reconstruction for 4x4 luma intra blocks.
- Takes the 16 predicted samples from a 4x4 intra predictor and adds a row-serial stream of signed residuals, clipping each sum to 8 bits.
- Emits reconstructed rows.
- After the last row, presents the neighbour samples that feed the predictor's A..M inputs for the next block.

Parameters:
- RES_W, 9, width of each signed residual sample (two's complement).
- PIX_W, 8, sample width. Clip range is 0..2^PIX_W-1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; latches pred_in and begins a block
- pred_in  in  16*PIX_W  prediction; sample r*4+c at bits [(r*4+c)*PIX_W +: PIX_W]
- res_valid  in  1  residual row valid
- res_ready  out  1  block accepts a residual row
- res_row  in  4*RES_W  residual row, column c at [c*RES_W +: RES_W]
- rec_valid  out  1  reconstructed row valid (1-cycle pulse)
- rec_row_idx  out  2  row number of rec_row
- rec_row  out  4*PIX_W  reconstructed row, column c at [c*PIX_W +: PIX_W]
- nbr_valid  out  1  neighbour outputs valid (1-cycle pulse)
- nbr_top  out  4*PIX_W  reconstructed row 3, cols 0..3; next block below uses it as A..D
- nbr_left  out  4*PIX_W  reconstructed column 3, rows 0..3; next block right uses it as I..L
- nbr_corner  out  PIX_W  reconstructed sample (3,3); corner M for the diagonal block
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on port reset.
- Reset values: FSM=IDLE, row counter=0, all outputs 0 (res_ready, rec_valid, nbr_valid, busy, rec_row, rec_row_idx, nbr_*).
- States:
  - IDLE -> ROWS on start. pred_in is captured into an internal 16-sample register on that edge. start is ignored in any other state.
  - ROWS: res_ready=1. A row is accepted on a cycle with res_valid & res_ready.
    - Each accepted row r: sum[c] = zero-extend(pred[r*4+c]) + sign-extend(res[c]), computed at RES_W+2 bits. Clip <0 -> 0, >2^PIX_W-1 -> 2^PIX_W-1.
    - rec_row, rec_row_idx=r and rec_valid=1 are registered, appearing on the cycle after acceptance. Latency is 1 cycle.
    - Column 3 of each row is stored for nbr_left. Row 3 is stored for nbr_top.
    - Row counter increments per accepted row. Acceptance of row 3 -> DONE.
    - Gaps (res_valid=0) stall without limit; no timeout.
  - DONE: one cycle. nbr_valid=1 with nbr_top, nbr_left and nbr_corner stable. This cycle coincides with rec_valid for row 3. Next state IDLE; res_ready=0.
- rec_valid has no backpressure; the consumer must take each row when pulsed.
- nbr_* hold their values after DONE until the next DONE or reset. rec_row holds its last value when rec_valid=0.
- start asserted in the DONE cycle is ignored. The earliest next start is the first IDLE cycle, giving a 6-cycle minimum block period at full rate.
- Reset mid-block: the block is abandoned; all state and outputs return to reset values on the next edge. No rec_valid or nbr_valid pulse is produced for the partial block.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: LUMA_RECON_CLIPCNT_EN.
- Defined:
  - Adds output port clip_count (5 bits): number of samples in the block whose sum was clipped, high or low (0..16).
  - Cleared on start. Valid and stable while nbr_valid=1; held afterward. Reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Flat block: pred all 0x80, residual rows all +5, res_valid held high -> rec_row=0x85858585 for rows 0..3 on 4 consecutive cycles. nbr_top=nbr_left=0x85858585, nbr_corner=0x85, nbr_valid in the row-3 rec_valid cycle.
- Clipping: pred 0xF0, residual +100 for cols 0..1; pred 0x10, residual -100 for cols 2..3 -> row=0x0000FFFF (col0 at LSB). With LUMA_RECON_CLIPCNT_EN, clip_count=16 when applied to all rows.
- Backpressure gaps: res_valid toggles 1,0,0,1,0,1,1 -> exactly 4 rec_valid pulses with rec_row_idx 0,1,2,3, each one cycle after acceptance. res_ready drops in the cycle after row 3 is accepted.
- Neighbour mapping: pred sample k = k, residual 0 -> nbr_left bytes 3,7,11,15 (rows 0..3), nbr_top bytes 12,13,14,15, nbr_corner=15.
- Reset after 2 rows accepted -> next cycle busy=0, res_ready=0, no nbr_valid. A new start then completes a full block correctly.
- start pulsed while in ROWS with a different pred_in -> ignored; output uses the originally latched prediction.
